ws2812_frame_sequencer: RTL and testbench

Upstream driver for `ws2812_rgb_controller`: holds a pixel frame buffer for a strip of `NUM_LEDS` LEDs, walks it pixel by pixel, presents each pixel's R/G/B and issues `CMD_TX` to the controller, then issues `CMD_RESET` to latch the frame. A host writes pixels through a simple write port at any time. The sequencer replaces the ad-hoc command loop used in simulation.

---
 rtl/ws2812_frame_sequencer_if.sv | 21 ++
 rtl/ws2812_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_sequencer_if.sv
// ws2812_frame_sequencer_if
//   Command/pixel link between the frame sequencer and ws2812_rgb_controller.
//   Signals:
//     cmd_req  - controller pulse: samples cmd this cycle
//     data_req - controller pulse: has captured r/g/b
//     r, g, b  - current pixel colour (8 bit each)
//     cmd      - 00 IDLE, 01 TX, 10 RESET
//   Modports:
//     master - sequencer side (drives cmd and r/g/b)
//     slave  - controller side (drives cmd_req and data_req)
interface ws2812_frame_sequencer_if;
    logic       cmd_req;
    logic       data_req;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] cmd;

    modport master (input cmd_req, input data_req, output r, output g, output b, output cmd);
    modport slave  (output cmd_req, output data_req, input r, input g, input b, input cmd);
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer
//   Holds a NUM_LEDS x 24-bit frame buffer written by a host, then walks it
//   pixel by pixel: presents r/g/b with CMD_TX to the controller, and after the
//   last pixel issues CMD_RESET to latch the frame.
//   Ports:
//     clk, rst   - single clock, synchronous active-high reset
//     wr_en      - host pixel write strobe
//     wr_addr    - pixel index (indices >= NUM_LEDS are dropped)
//     wr_data    - {R, G, B}
//     start      - one-cycle frame start request, ignored while busy
//     link       - controller link (cmd_req/data_req in, cmd/r/g/b out)
//     busy       - high from accepted start until frame_done
//     frame_done - one-cycle pulse when the latch command completes
//     underrun   - one-cycle pulse on cmd_req while the next pixel is not ready
//   Optional feature: define WS2812_SEQ_AUTOREPEAT_EN to restart the next frame
//   automatically after each latch, until rst.
module ws2812_frame_sequencer #(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [23:0]          wr_data,
    input  logic                 start,
    ws2812_frame_sequencer_if.master link,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE_TX, S_WAIT_DATA, S_ISSUE_RESET, S_WAIT_RESET
    } state_t;

    localparam logic [1:0]        CMD_IDLE  = 2'b00;
    localparam logic [1:0]        CMD_TX    = 2'b01;
    localparam logic [1:0]        CMD_RESET = 2'b10;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pix_idx, idx_n;
    logic [23:0]       rgb_n;
    logic [1:0]        cmd_n;
    logic              busy_n, done_n, underrun_n;

    // Depth covers the whole address space so every index is in range; only
    // the first NUM_LEDS entries are ever written or read.
    logic [23:0] mem [2**ADDR_W];
    logic [23:0] rd_data;

    // Non-blocking read alongside the write gives read-first behaviour: a
    // same-cycle write to the fetched pixel lands after the old value is read.
    always_ff @(posedge clk) begin
        if (wr_en && (int'({1'b0, wr_addr}) < NUM_LEDS))
            mem[wr_addr] <= wr_data;
        rd_data <= mem[pix_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pix_idx    <= '0;
            link.r     <= '0;
            link.g     <= '0;
            link.b     <= '0;
            link.cmd   <= CMD_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            pix_idx    <= idx_n;
            {link.r, link.g, link.b} <= rgb_n;
            link.cmd   <= cmd_n;
            busy       <= busy_n;
            frame_done <= done_n;
            underrun   <= underrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = pix_idx;
        rgb_n      = {link.r, link.g, link.b};
        cmd_n      = link.cmd;
        busy_n     = busy;
        done_n     = 1'b0;
        underrun_n = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_n  = CMD_IDLE;
                busy_n = 1'b0;
                if (start) begin
                    state_n = S_FETCH;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                rgb_n   = rd_data;
                cmd_n   = CMD_TX;
                state_n = S_ISSUE_TX;
            end
            S_ISSUE_TX: begin
                if (link.cmd_req) begin
                    cmd_n   = CMD_IDLE;
                    state_n = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (link.data_req) begin
                    if (pix_idx == LAST_IDX) begin
                        cmd_n   = CMD_RESET;
                        state_n = S_ISSUE_RESET;
                    end else begin
                        idx_n   = pix_idx + 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            S_ISSUE_RESET: begin
                if (link.cmd_req) begin
                    cmd_n   = CMD_IDLE;
                    state_n = S_WAIT_RESET;
                end
            end
            S_WAIT_RESET: begin
                if (link.cmd_req) begin
                    done_n = 1'b1;
`ifdef WS2812_SEQ_AUTOREPEAT_EN
                    state_n = S_FETCH;
                    idx_n   = '0;
`else
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Controller asked for a command before the next pixel was loaded:
        // cmd is already IDLE here, so it just idles one slot.
        if (link.cmd_req && (state == S_FETCH || state == S_LOAD || state == S_WAIT_DATA))
            underrun_n = 1'b1;
    end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
module tb_ws2812_frame_sequencer;
    localparam int N  = 3;
    localparam int AW = 3;

    logic          clk, rst, wr_en, start, busy, frame_done, underrun;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    int            vectors = 0;
    int            miscompares = 0;
    logic [23:0]   model_mem [N];

    ws2812_frame_sequencer_if ifc ();

    ws2812_frame_sequencer #(.NUM_LEDS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .link(ifc), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Host write; the model keeps only in-range pixels.
    task automatic host_write(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        if (a < N) model_mem[a] = d;
    endtask

    task automatic wait_cmd(input logic [1:0] want, input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.cmd === want) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) chk(tag, ifc.cmd, want);
    endtask

    // start -> busy after the edge, TX with pixel 0 two edges later.
    task automatic start_frame();
        start = 1'b1; step(); start = 1'b0;
        chk("start_busy", {busy, ifc.cmd}, 3'b100);
        step();
        chk("start_n1_cmd", ifc.cmd, 2'b00);
        step();
        chk("start_n2_cmd", ifc.cmd, 2'b01);
        chk("start_n2_pix", {ifc.r, ifc.g, ifc.b}, model_mem[0]);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_ignored", {busy, ifc.cmd, ifc.r, ifc.g, ifc.b}, {1'b1, 2'b01, model_mem[0]});
    endtask

    // Acts as the controller for one frame.
    // early_kind 1: cmd_req one clock after data_req; 2: cmd_req with data_req.
    task automatic ctrl_frame(input int early_at, input int early_kind, input int write_at,
                              input logic [23:0] wr_val, input int abort_at);
        bit ok;
        for (int k = 0; k < N; k++) begin
            wait_cmd(2'b01, "tx_timeout", ok);
            if (!ok) return;
            chk("pix", {ifc.r, ifc.g, ifc.b}, model_mem[k]);
            chk("busy_tx", busy, 1'b1);
            if (k == abort_at) begin
                rst = 1'b1; step(); rst = 1'b0;
                chk("abort_outputs", {ifc.cmd, ifc.r, ifc.g, ifc.b, busy, frame_done, underrun}, '0);
                repeat (3) begin
                    step();
                    chk("abort_idle", {busy, frame_done, ifc.cmd}, 3'b000);
                end
                return;
            end
            if (k == write_at && k + 1 < N) host_write(k + 1, wr_val);
            repeat ($urandom_range(0, 4)) step();
            chk("tx_hold", ifc.cmd, 2'b01);
            ifc.cmd_req = 1'b1; step(); ifc.cmd_req = 1'b0;
            chk("tx_ack", {ifc.cmd, underrun}, 3'b000);
            repeat ($urandom_range(0, 3)) step();
            if (k == early_at && early_kind == 2) begin
                ifc.data_req = 1'b1; ifc.cmd_req = 1'b1; step();
                ifc.data_req = 1'b0; ifc.cmd_req = 1'b0;
                chk("underrun_same", underrun, 1'b1);
            end else begin
                ifc.data_req = 1'b1; step(); ifc.data_req = 1'b0;
                chk("no_underrun", underrun, 1'b0);
                if (k == early_at && early_kind == 1) begin
                    ifc.cmd_req = 1'b1; step(); ifc.cmd_req = 1'b0;
                    chk("underrun_early", {ifc.cmd, underrun}, 3'b001);
                end
            end
        end
        wait_cmd(2'b10, "reset_timeout", ok);
        if (!ok) return;
        repeat ($urandom_range(0, 4)) step();
        ifc.cmd_req = 1'b1; step(); ifc.cmd_req = 1'b0;
        chk("reset_ack", {ifc.cmd, busy, frame_done}, 4'b0010);
        repeat ($urandom_range(0, 4)) step();
        ifc.cmd_req = 1'b1; step(); ifc.cmd_req = 1'b0;
        chk("frame_done", frame_done, 1'b1);
`ifdef WS2812_SEQ_AUTOREPEAT_EN
        chk("busy_repeat", busy, 1'b1);
`else
        chk("busy_done", busy, 1'b0);
`endif
        step();
        chk("done_pulse", frame_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        ifc.cmd_req = 1'b0; ifc.data_req = 1'b0;
        step(); step();
        chk("rst_cmd", ifc.cmd, 2'b00);
        chk("rst_rgb", {ifc.r, ifc.g, ifc.b}, 24'h0);
        chk("rst_flags", {busy, frame_done, underrun}, 3'b000);
        rst = 1'b0;
        step();

        host_write(0, 24'hFF0080);
        host_write(1, 24'h00FF00);
        host_write(2, 24'h0000FF);

`ifdef WS2812_SEQ_AUTOREPEAT_EN
        start_frame();
        for (int f = 0; f < 3; f++) ctrl_frame(-1, 0, -1, 24'h0, -1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("repeat_rst", {busy, ifc.cmd}, 3'b000);
`else
        // Reference frame with the nominal controller.
        start_frame();
        ctrl_frame(-1, 0, -1, 24'h0, -1);
        repeat (3) begin
            step();
            chk("idle_after", {busy, ifc.cmd}, 3'b000);
        end

        // Out-of-range write dropped, early cmd_req, write during pixel 1.
        host_write(5, 24'hABCDEF);
        start_frame();
        ctrl_frame(0, 1, 1, 24'h123456, -1);
        chk("pix2_new", model_mem[2], 24'h123456);

        // cmd_req together with data_req.
        start_frame();
        ctrl_frame(1, 2, -1, 24'h0, -1);

        // Reset during ISSUE_TX of pixel 1, then buffer survives.
        start_frame();
        ctrl_frame(-1, 0, -1, 24'h0, 1);
        start_frame();
        ctrl_frame(-1, 0, -1, 24'h0, -1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) host_write(int'($urandom_range(0, 7)), 24'($urandom));
            start_frame();
            ctrl_frame(int'($urandom_range(0, 2)) - 1, int'($urandom_range(1, 2)),
                       int'($urandom_range(0, 2)) - 1, 24'($urandom), -1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
